// File: rtl/core_cp_pkg.sv
// core_cp_pkg: shared column map, core state encoding and rst_len floor for the core control table.
package core_cp_pkg;
   localparam logic [14:0] COL_DSID    = 15'd0;
   localparam logic [14:0] COL_STATE   = 15'd1;
   localparam logic [14:0] COL_RSTLEN  = 15'd2;
   localparam logic [14:0] COL_BUSY    = 15'd3;
   localparam logic [14:0] COL_WAKECNT = 15'd4;
   localparam logic [7:0]  RST_LEN_MIN = 8'd4;

   typedef enum logic {
      STATE_SLEEP   = 1'b0,
      STATE_RUNNING = 1'b1
   } core_state_e;

   function automatic logic [7:0] clamp_len(input logic [7:0] v);
      return (v < RST_LEN_MIN) ? RST_LEN_MIN : v;
   endfunction
endpackage

// File: rtl/core_cp_rst_pulse.sv
// core_cp_rst_pulse: one core's wake-edge detector and reset-pulse down-counter.
// The edge is taken against the next state so the pulse starts the cycle right after the state write.
module core_cp_rst_pulse
   import core_cp_pkg::*;
(
   input  logic        SYS_CLK,
   input  logic        DETECT_RST,
   input  core_state_e state_nxt,
   input  logic [7:0]  rst_len,
   output logic        rise,
   output logic        rst_busy
);
   core_state_e last_state;
   logic [7:0]  counter;

   assign rise     = (state_nxt == STATE_RUNNING) && (last_state == STATE_SLEEP);
   assign rst_busy = counter != 8'd0;

   always_ff @(posedge SYS_CLK) begin
      if (DETECT_RST) begin
         last_state <= STATE_SLEEP;
         counter    <= 8'd0;
      end else begin
         last_state <= state_nxt;
         counter    <= rise ? rst_len : rst_busy ? counter - 8'd1 : counter;
      end
   end
endmodule

// File: rtl/core_cp_ptab_mc.sv
// core_cp_ptab_mc: per-core control table (dsid, run state, reset length) driving active-low core resets.
// Define CORE_CP_PTAB_WAKE_CNT_EN to add a read-only per-core wake counter at column 4.
module core_cp_ptab_mc
   import core_cp_pkg::*;
#(
   parameter int NUM_CORES   = 4,
   parameter int DSID_W      = 16,
   parameter int RST_LEN_DEF = 8,
   parameter int SLEEP_HOLD  = 0
) (
   input  logic                        SYS_CLK,
   input  logic                        DETECT_RST,
   input  logic                        is_this_table,
   input  logic [14:0]                 col,
   input  logic [14:0]                 row,
   input  logic [63:0]                 wdata,
   input  logic                        wen,
   output logic [63:0]                 rdata,
   output logic [NUM_CORES-1:0]        EXT_RESET_IN_CORE,
   output logic [NUM_CORES*DSID_W-1:0] DS_ID_CORE
);
   localparam logic [14:0] NC = 15'(NUM_CORES);

   logic        wr_ok;
   logic [63:0] rd_field [NUM_CORES];
   logic        unused_wdata;

   assign wr_ok        = wen && is_this_table && (row < NC);
   assign unused_wdata = ^wdata;

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
      logic              sel;
      core_state_e       state;
      core_state_e       state_nxt;
      logic [DSID_W-1:0] dsid;
      logic [7:0]        rst_len;
      logic              rise;
      logic              rst_busy;
      logic [63:0]       wake_rd;

      assign sel       = wr_ok && (row == 15'(i));
      assign state_nxt = (sel && col == COL_STATE) ? core_state_e'(wdata[0]) : state;

      always_ff @(posedge SYS_CLK) begin
         if (DETECT_RST) begin
            dsid    <= '0;
            state   <= STATE_SLEEP;
            rst_len <= 8'(RST_LEN_DEF);
         end else begin
            state <= state_nxt;
            if (sel && col == COL_DSID) dsid <= wdata[DSID_W-1:0];
            if (sel && col == COL_RSTLEN) rst_len <= clamp_len(wdata[7:0]);
         end
      end

      core_cp_rst_pulse u_pulse (
         .SYS_CLK   (SYS_CLK),
         .DETECT_RST(DETECT_RST),
         .state_nxt (state_nxt),
         .rst_len   (rst_len),
         .rise      (rise),
         .rst_busy  (rst_busy)
      );

`ifdef CORE_CP_PTAB_WAKE_CNT_EN
      logic [15:0] wake_cnt;
      // A clearing state write wins over the wake it may cause in the same cycle.
      always_ff @(posedge SYS_CLK) begin
         if (DETECT_RST) wake_cnt <= '0;
         else if (sel && col == COL_STATE && wdata[1]) wake_cnt <= '0;
         else if (rise) wake_cnt <= wake_cnt + 16'd1;
      end
      assign wake_rd = 64'(wake_cnt);
`else
      logic unused_rise;
      assign unused_rise = rise;
      assign wake_rd     = '0;
`endif

      assign rd_field[i] = (col == COL_DSID)    ? 64'(dsid)     :
                           (col == COL_STATE)   ? 64'(state)    :
                           (col == COL_RSTLEN)  ? 64'(rst_len)  :
                           (col == COL_BUSY)    ? 64'(rst_busy) :
                           (col == COL_WAKECNT) ? wake_rd       : '0;

      assign EXT_RESET_IN_CORE[i]          = ~(rst_busy || (SLEEP_HOLD != 0 && state == STATE_SLEEP));
      assign DS_ID_CORE[i*DSID_W +: DSID_W] = dsid;
   end

   always_comb begin
      rdata = '0;
      for (int k = 0; k < NUM_CORES; k++) if (row == 15'(k)) rdata = rd_field[k];
   end
endmodule
